exec_result_stage: RTL and testbench

- Registered result stage directly downstream of the execute-stage logic ops (XOR_N and siblings) and the adder.
- Captures the selected ALU result plus destination register, and computes Z/N flags at capture.
- Two-entry skid buffer with valid/ready handshakes on both sides, so memory-stage stalls never create a combinational ready path back into execute.
- Holds the architectural NZCV flag register, updated as flag-setting results retire to the memory stage.

---
 rtl/exec_result_stage.sv | 121 ++++++++++++
 tb/tb_exec_result_stage.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_result_stage.sv
// Execute-to-memory result stage: two-entry skid buffer carrying ALU results with Z/N
// computed at capture, plus the architectural NZCV register updated as results retire.
module exec_result_stage #(
    parameter int unsigned REGISTER_LENGTH = 64,
    parameter int unsigned RD_WIDTH        = 5
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [REGISTER_LENGTH-1:0] result_i,
    input  logic [RD_WIDTH-1:0]        rd_i,
    input  logic                       set_flags_i,
    input  logic                       carry_i,
    input  logic                       overflow_i,
    input  logic                       flush_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [REGISTER_LENGTH-1:0] result_o,
    output logic [RD_WIDTH-1:0]        rd_o,
    output logic                       set_flags_o,
    output logic                       zero_o,
    output logic                       negative_o,
    output logic [3:0]                 nzcv_o
);

    typedef struct packed {
        logic [REGISTER_LENGTH-1:0] result;
        logic [RD_WIDTH-1:0]        rd;
        logic                       set_flags;
        logic                       z;
        logic                       n;
        logic                       c;
        logic                       v;
    } entry_t;

    entry_t     in_entry;
    entry_t     head, head_d;
    entry_t     skid, skid_d;
    logic       head_valid, head_valid_d;
    logic       skid_valid, skid_valid_d;
    logic [3:0] nzcv, nzcv_d;
    logic       in_xfer;
    logic       out_xfer;

    // C/V only carry meaning for flag-setting instructions; store zero otherwise.
    always_comb begin
        in_entry.result    = result_i;
        in_entry.rd        = rd_i;
        in_entry.set_flags = set_flags_i;
        in_entry.z         = (result_i == '0);
        in_entry.n         = result_i[REGISTER_LENGTH-1];
        in_entry.c         = set_flags_i & carry_i;
        in_entry.v         = set_flags_i & overflow_i;
    end

    // Ready depends only on registered state, never on out_ready_i.
    assign in_ready_o = ~skid_valid;
    assign in_xfer    = in_valid_i & in_ready_o;
    assign out_xfer   = head_valid & out_ready_i;

    always_comb begin
        head_d       = head;
        skid_d       = skid;
        head_valid_d = head_valid;
        skid_valid_d = skid_valid;
        nzcv_d       = nzcv;

        // A retiring entry updates flags even in a flush cycle: downstream has consumed it.
        if (out_xfer && head.set_flags) begin
            nzcv_d = {head.n, head.z, head.c, head.v};
        end

        if (flush_i) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_xfer) begin
            if (skid_valid) begin
                head_d       = skid;
                skid_valid_d = 1'b0;
            end else if (in_xfer) begin
                head_d = in_entry;
            end else begin
                head_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            if (!head_valid) begin
                head_d       = in_entry;
                head_valid_d = 1'b1;
            end else begin
                skid_d       = in_entry;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            head       <= '0;
            skid       <= '0;
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
            nzcv       <= 4'b0000;
        end else begin
            head       <= head_d;
            skid       <= skid_d;
            head_valid <= head_valid_d;
            skid_valid <= skid_valid_d;
            nzcv       <= nzcv_d;
        end
    end

    assign out_valid_o = head_valid;
    assign result_o    = head.result;
    assign rd_o        = head.rd;
    assign set_flags_o = head.set_flags;
    assign zero_o      = head.z;
    assign negative_o  = head.n;
    assign nzcv_o      = nzcv;

endmodule

// File: tb/tb_exec_result_stage.sv
// Bench for exec_result_stage: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_exec_result_stage;

    localparam int unsigned W  = 64;
    localparam int unsigned RW = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  result_in;
    logic [RW-1:0] rd_in;
    logic          set_flags_in;
    logic          carry_in;
    logic          overflow_in;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result_out;
    logic [RW-1:0] rd_out;
    logic          set_flags_out;
    logic          zero_out;
    logic          negative_out;
    logic [3:0]    nzcv_out;

    exec_result_stage #(.REGISTER_LENGTH(W), .RD_WIDTH(RW)) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .result_i    (result_in),
        .rd_i        (rd_in),
        .set_flags_i (set_flags_in),
        .carry_i     (carry_in),
        .overflow_i  (overflow_in),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result_out),
        .rd_o        (rd_out),
        .set_flags_o (set_flags_out),
        .zero_o      (zero_out),
        .negative_o  (negative_out),
        .nzcv_o      (nzcv_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  r;
        logic [RW-1:0] rd;
        logic          sf;
        logic          c;
        logic          v;
    } ment_t;

    ment_t      mq[$];
    logic [3:0] m_nzcv;
    int         n_pass  = 0;
    int         n_total = 0;
    bit         chk_en  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        else n_pass++;
    endtask

    function automatic logic [3:0] flags_of(input ment_t e);
        logic [W-1:0] r;
        r = e.r;
        return {r[W-1], (r == 0), e.c, e.v};
    endfunction

    // Reference model: a FIFO of at most two results, advanced once per rising edge.
    task automatic model_step();
        bit    it, ot;
        ment_t e;
        it = in_valid && (mq.size() < 2);
        ot = out_ready && (mq.size() > 0);
        if (ot) begin
            e = mq.pop_front();
            if (e.sf) m_nzcv = flags_of(e);
        end
        if (flush) mq.delete();
        else if (it) begin
            e.r  = result_in;
            e.rd = rd_in;
            e.sf = set_flags_in;
            e.c  = set_flags_in & carry_in;
            e.v  = set_flags_in & overflow_in;
            mq.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_step();
        @(negedge clk);
        #1;
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
            chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
            chk("nzcv", 64'(nzcv_out), 64'(m_nzcv));
            if (mq.size() > 0) begin
                chk("result", result_out, mq[0].r);
                chk("rd", 64'(rd_out), 64'(mq[0].rd));
                chk("set_flags", 64'(set_flags_out), 64'(mq[0].sf));
                chk("zero", 64'(zero_out), 64'(flags_of(mq[0]) >> 2) & 64'h1);
                chk("negative", 64'(negative_out), 64'(flags_of(mq[0]) >> 3));
            end
        end
    end

    task automatic drive(input logic v, input logic [W-1:0] r, input logic [RW-1:0] d,
                         input logic sf, input logic c, input logic ov);
        in_valid     = v;
        result_in    = r;
        rd_in        = d;
        set_flags_in = sf;
        carry_in     = c;
        overflow_in  = ov;
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        m_nzcv = 4'b0000;
        repeat (3) @(negedge clk);
        #1;
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // Reset state
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h1);
        chk("rst_nzcv", 64'(nzcv_out), 64'h0);

        // Single transfer, then flag retirement
        out_ready = 1'b1;
        drive(1'b1, 64'hFFFF_0000_0000_0001, 5'd7, 1'b1, 1'b1, 1'b0);
        tick();
        chk("t1_out_valid", 64'(out_valid), 64'h1);
        chk("t1_result", result_out, 64'hFFFF_0000_0000_0001);
        chk("t1_rd", 64'(rd_out), 64'd7);
        chk("t1_zero", 64'(zero_out), 64'h0);
        chk("t1_negative", 64'(negative_out), 64'h1);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("t1_nzcv", 64'(nzcv_out), 64'hA);
        chk("t1_empty", 64'(out_valid), 64'h0);

        // Back-to-back stream at full throughput
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 64'(i), 5'(i), 1'b0, 1'b0, 1'b0);
            tick();
            chk("b2b_valid", 64'(out_valid), 64'h1);
            chk("b2b_result", result_out, 64'(i));
            chk("b2b_in_ready", 64'(in_ready), 64'h1);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("b2b_drain", 64'(out_valid), 64'h0);

        // Backpressure: fill head and skid, third input held off
        out_ready = 1'b0;
        drive(1'b1, 64'h5, 5'd1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("bp_a_head", result_out, 64'h5);
        chk("bp_a_in_ready", 64'(in_ready), 64'h1);
        drive(1'b1, 64'h0, 5'd2, 1'b0, 1'b0, 1'b0);
        tick();
        chk("bp_full_in_ready", 64'(in_ready), 64'h0);
        drive(1'b1, 64'h9, 5'd3, 1'b0, 1'b0, 1'b0);
        tick();
        chk("bp_hold_result", result_out, 64'h5);
        chk("bp_hold_in_ready", 64'(in_ready), 64'h0);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        chk("bp_b_result", result_out, 64'h0);
        chk("bp_b_zero", 64'(zero_out), 64'h1);
        tick();
        chk("bp_empty", 64'(out_valid), 64'h0);

        // Flush while full discards both entries and the incoming one
        out_ready = 1'b0;
        drive(1'b1, 64'h5, 5'd4, 1'b1, 1'b1, 1'b1);
        tick();
        drive(1'b1, 64'h6, 5'd5, 1'b1, 1'b0, 1'b1);
        tick();
        flush = 1'b1;
        drive(1'b1, 64'h3, 5'd6, 1'b1, 1'b0, 1'b0);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("fl_out_valid", 64'(out_valid), 64'h0);
        chk("fl_in_ready", 64'(in_ready), 64'h1);
        chk("fl_nzcv", 64'(nzcv_out), 64'hA);
        tick();
        chk("fl_still_empty", 64'(out_valid), 64'h0);

        // Flush coincident with retirement of a zero result
        drive(1'b1, 64'h0, 5'd8, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        flush = 1'b0;
        chk("flot_nzcv", 64'(nzcv_out), 64'h4);
        chk("flot_empty", 64'(out_valid), 64'h0);
        chk("flot_in_ready", 64'(in_ready), 64'h1);

        // Async reset with both entries full; N and Z cannot both be set, so 1011 is the
        // richest reachable flag value.
        drive(1'b1, {W{1'b1}}, 5'd9, 1'b1, 1'b1, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("ar_nzcv_pre", 64'(nzcv_out), 64'hB);
        out_ready = 1'b0;
        drive(1'b1, 64'h11, 5'd1, 1'b1, 1'b1, 1'b1);
        tick();
        drive(1'b1, 64'h22, 5'd2, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("ar_full", 64'(in_ready), 64'h0);
        #1;
        reset_n = 1'b0;
        mq.delete();
        m_nzcv = 4'b0000;
        #1;
        chk("ar_out_valid", 64'(out_valid), 64'h0);
        chk("ar_in_ready", 64'(in_ready), 64'h1);
        chk("ar_nzcv", 64'(nzcv_out), 64'h0);
        @(negedge clk);
        #1;
        reset_n = 1'b1;

        // Randomized traffic checked by the per-cycle model comparison
        for (int i = 0; i < 3000; i++) begin
            logic [W-1:0] r;
            r = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: r = '0;
                1: r[W-1] = 1'b1;
                default: ;
            endcase
            drive(($urandom_range(0, 9) < 7), r, 5'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom));
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 99) < 3);
            tick();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        chk("final_drained", 64'(out_valid), 64'h0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
